// File: rtl/cs161_mc_control_if.sv
// ----------------------------------------------------------------------------
// cs161_mc_control_if
//
// Purpose:
//   Bundles every signal exchanged between the multicycle main control unit
//   and the cs161 datapath. The controller is the master: it drives the
//   control strobes. The datapath (or a testbench acting for it) is the
//   slave: it drives the opcode and funct fields and the memory ready
//   handshake.
//
// Signal summary:
//   instr_op      [5:0]          opcode from the instruction register
//   funct         [5:0]          funct field from the instruction register
//   mem_ready                    memory completes the current access
//   funct_out     [5:0]          funct copy captured during DECODE
//   pc_write                     unconditional PC load
//   pc_write_cond                PC load when the ALU zero flag is set
//   pc_source     [1:0]          00 ALU result, 01 ALUOut, 10 jump target
//   i_or_d                       0 PC address, 1 ALUOut data address
//   mem_read / mem_write         memory access requests
//   ir_write                     instruction register load
//   mem_to_reg                   write-back source: 1 MDR, 0 ALUOut
//   reg_dst                      1 rd, 0 rt
//   reg_write                    register file write enable
//   alu_src_a                    0 PC, 1 rs
//   alu_src_b     [1:0]          00 rt, 01 four, 10 imm, 11 imm<<2
//   alu_op        [ALU_OP_W-1:0] 0000 add, 0001 sub, 0010 decode funct
// ----------------------------------------------------------------------------
interface cs161_mc_control_if #(
    parameter int ALU_OP_W = 4
);
    logic [5:0]          instr_op;
    logic [5:0]          funct;
    logic                mem_ready;

    logic [5:0]          funct_out;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;

    // Controller side
    modport master (
        input  instr_op, funct, mem_ready,
        output funct_out, pc_write, pc_write_cond, pc_source, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, alu_op
    );

    // Datapath side
    modport slave (
        output instr_op, funct, mem_ready,
        input  funct_out, pc_write, pc_write_cond, pc_source, i_or_d,
               mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, alu_op
    );
endinterface

// File: rtl/cs161_mc_control.sv
// ----------------------------------------------------------------------------
// cs161_mc_control
//
// Purpose:
//   Multicycle main control unit for the cs161 datapath. Each instruction is
//   walked through 3-5 states, and every datapath strobe is decoded from the
//   current state. Memory states wait on a ready handshake; a wait that runs
//   too long traps into a sticky ERROR state. Unknown opcodes trap the same
//   way. A retired-instruction counter is kept for debug.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   bus            controller side of cs161_mc_control_if (master modport)
//   o_state_dbg    current state encoding
//   o_error        trap flag, held until reset
//   o_instr_count  retired instruction count, wraps modulo 2^CNT_W
// ----------------------------------------------------------------------------
module cs161_mc_control #(
    parameter int ALU_OP_W = 4,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cs161_mc_control_if.master   bus,
    output logic [3:0]           o_state_dbg,
    output logic                 o_error,
    output logic [CNT_W-1:0]     o_instr_count
);

    localparam int WAIT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_ERROR  = 4'd15
    } state_t;

    state_t              r_state;
    logic                r_active;
    logic [WAIT_W-1:0]   r_waitCount;
    logic [CNT_W-1:0]    r_instrCount;
    logic [5:0]          r_functOut;

    logic                w_waitExpired;
    logic                w_pcWrite;
    logic                w_pcWriteCond;
    logic [1:0]          w_pcSource;
    logic                w_iOrD;
    logic                w_memRead;
    logic                w_memWrite;
    logic                w_irWrite;
    logic                w_memToReg;
    logic                w_regDst;
    logic                w_regWrite;
    logic                w_aluSrcA;
    logic [1:0]          w_aluSrcB;
    logic [ALU_OP_W-1:0] w_aluOp;
    logic                w_error;

    // The wait budget is spent once the counter has reached WAIT_MAX and
    // memory is still not ready; a ready in that same cycle still succeeds.
    assign w_waitExpired = !bus.mem_ready &&
                           (r_waitCount == WAIT_W'(WAIT_MAX));

    // Sequencer: state, wait counter, retire counter and the funct capture.
    // r_active stays low for the first edge after reset release so that the
    // strobes are held off until the cycle following the rst_n rising edge.
    // The wait counter defaults to clear and only counts while a memory
    // state is stalled, so any state change or ready clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_active     <= 1'b0;
            r_waitCount  <= '0;
            r_instrCount <= '0;
            r_functOut   <= '0;
        end else if (!r_active) begin
            r_active <= 1'b1;
        end else begin
            r_waitCount <= '0;
            case (r_state)
                S_FETCH: begin
                    if (bus.mem_ready)       r_state <= S_DECODE;
                    else if (w_waitExpired)  r_state <= S_ERROR;
                    else                     r_waitCount <= r_waitCount + WAIT_W'(1);
                end
                S_DECODE: begin
                    r_functOut <= bus.funct;
                    case (bus.instr_op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXEC;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_J:         r_state <= S_JMP;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        default:      r_state <= S_ERROR;
                    endcase
                end
                S_MEMADR: r_state <= (bus.instr_op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD: begin
                    if (bus.mem_ready)       r_state <= S_MEMWB;
                    else if (w_waitExpired)  r_state <= S_ERROR;
                    else                     r_waitCount <= r_waitCount + WAIT_W'(1);
                end
                S_MEMWR: begin
                    if (bus.mem_ready) begin
                        r_state      <= S_FETCH;
                        r_instrCount <= r_instrCount + CNT_W'(1);
                    end else if (w_waitExpired) begin
                        r_state <= S_ERROR;
                    end else begin
                        r_waitCount <= r_waitCount + WAIT_W'(1);
                    end
                end
                S_MEMWB, S_RWB, S_BEQ, S_JMP, S_ADDIWB: begin
                    r_state      <= S_FETCH;
                    r_instrCount <= r_instrCount + CNT_W'(1);
                end
                S_EXEC:   r_state <= S_RWB;
                S_ADDIEX: r_state <= S_ADDIWB;
                S_ERROR:  r_state <= S_ERROR;
                default:  r_state <= S_ERROR;
            endcase
        end
    end

    // Strobe decode from the state register. Everything is held at zero
    // until r_active rises, which also makes an asynchronous reset drop the
    // strobes immediately. FETCH only loads IR and PC once memory is ready.
    always_comb begin
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_pcSource    = 2'b00;
        w_iOrD        = 1'b0;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_irWrite     = 1'b0;
        w_memToReg    = 1'b0;
        w_regDst      = 1'b0;
        w_regWrite    = 1'b0;
        w_aluSrcA     = 1'b0;
        w_aluSrcB     = 2'b00;
        w_aluOp       = ALU_ADD;
        w_error       = 1'b0;
        if (r_active) begin
            case (r_state)
                S_FETCH: begin
                    w_memRead = 1'b1;
                    w_aluSrcB = 2'b01;
                    w_irWrite = bus.mem_ready;
                    w_pcWrite = bus.mem_ready;
                end
                S_DECODE: w_aluSrcB = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    w_aluSrcA = 1'b1;
                    w_aluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    w_memRead = 1'b1;
                    w_iOrD    = 1'b1;
                end
                S_MEMWB: begin
                    w_regWrite = 1'b1;
                    w_memToReg = 1'b1;
                end
                S_MEMWR: begin
                    w_memWrite = 1'b1;
                    w_iOrD     = 1'b1;
                end
                S_EXEC: begin
                    w_aluSrcA = 1'b1;
                    w_aluOp   = ALU_FUNCT;
                end
                S_RWB: begin
                    w_regWrite = 1'b1;
                    w_regDst   = 1'b1;
                end
                S_BEQ: begin
                    w_aluSrcA     = 1'b1;
                    w_aluOp       = ALU_SUB;
                    w_pcWriteCond = 1'b1;
                    w_pcSource    = 2'b01;
                end
                S_JMP: begin
                    w_pcWrite  = 1'b1;
                    w_pcSource = 2'b10;
                end
                S_ADDIWB: w_regWrite = 1'b1;
                S_ERROR:  w_error    = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.funct_out     = r_functOut;
    assign bus.pc_write      = w_pcWrite;
    assign bus.pc_write_cond = w_pcWriteCond;
    assign bus.pc_source     = w_pcSource;
    assign bus.i_or_d        = w_iOrD;
    assign bus.mem_read      = w_memRead;
    assign bus.mem_write     = w_memWrite;
    assign bus.ir_write      = w_irWrite;
    assign bus.mem_to_reg    = w_memToReg;
    assign bus.reg_dst       = w_regDst;
    assign bus.reg_write     = w_regWrite;
    assign bus.alu_src_a     = w_aluSrcA;
    assign bus.alu_src_b     = w_aluSrcB;
    assign bus.alu_op        = w_aluOp;

    assign o_state_dbg   = r_state;
    assign o_error       = w_error;
    assign o_instr_count = r_instrCount;

endmodule

// File: tb/tb_cs161_mc_control.sv
// ----------------------------------------------------------------------------
// tb_cs161_mc_control
//
// Purpose:
//   Self-checking bench for cs161_mc_control. Each instruction is described
//   by its list of states; memory states get a chosen number of not-ready
//   cycles. Every cycle the full strobe set is compared against a table of
//   what each state must drive, and the retire count is tracked as a simple
//   number of completed instructions.
// ----------------------------------------------------------------------------
module tb_cs161_mc_control;

    localparam int WAIT_MAX = 15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic [3:0] st;
        logic       err;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcs;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       sa;
        logic [1:0] sb;
        logic [3:0] aop;
    } ctrl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  o_state_dbg;
    logic        o_error;
    logic [31:0] o_instr_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expCount = '0;
    ctrl_t       actCtrl;
    ctrl_t       zeroCtrl = '0;

    cs161_mc_control_if #(.ALU_OP_W(4)) bus ();

    cs161_mc_control #(
        .ALU_OP_W (4),
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .o_state_dbg   (o_state_dbg),
        .o_error       (o_error),
        .o_instr_count (o_instr_count)
    );

    always #5 clk = ~clk;

    assign actCtrl = {o_state_dbg, o_error, bus.pc_write, bus.pc_write_cond,
                      bus.pc_source, bus.i_or_d, bus.mem_read, bus.mem_write,
                      bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
                      bus.alu_src_a, bus.alu_src_b, bus.alu_op};

    // What each state must drive, straight from the control table.
    function automatic ctrl_t expCtrl(input int st, input logic rdy);
        ctrl_t e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.mrd = 1'b1; e.sb = 2'b01; e.irw = rdy; e.pcw = rdy; end
            1:  e.sb = 2'b11;
            2:  begin e.sa = 1'b1; e.sb = 2'b10; end
            3:  begin e.mrd = 1'b1; e.iord = 1'b1; end
            4:  begin e.rw = 1'b1; e.m2r = 1'b1; end
            5:  begin e.mwr = 1'b1; e.iord = 1'b1; end
            6:  begin e.sa = 1'b1; e.aop = 4'b0010; end
            7:  begin e.rw = 1'b1; e.rdst = 1'b1; end
            8:  begin e.sa = 1'b1; e.aop = 4'b0001; e.pcwc = 1'b1; e.pcs = 2'b01; end
            9:  begin e.pcw = 1'b1; e.pcs = 2'b10; end
            10: begin e.sa = 1'b1; e.sb = 2'b10; end
            11: e.rw = 1'b1;
            15: e.err = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Hold reset for two cycles and release; the bench resumes just after
    // the first edge following release, with the unit parked in FETCH.
    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        expCount = '0;
    endtask

    // Runs one instruction through its state path. fetchWait/memWait give
    // the not-ready cycles in FETCH and in MEMRD/MEMWR; a wait beyond
    // WAIT_MAX must trap. rndReady randomises mem_ready where it is ignored.
    task automatic run_instr(input logic [5:0] op, input int fetchWait,
                             input int memWait, input bit rndReady,
                             input string tag);
        int    path[$];
        logic [5:0] f;
        bit    trapped;
        int    st, w, n;
        ctrl_t e;
        case (op)
            OP_RTYPE: path = '{0, 1, 6, 7};
            OP_LW:    path = '{0, 1, 2, 3, 4};
            OP_SW:    path = '{0, 1, 2, 5};
            OP_BEQ:   path = '{0, 1, 8};
            OP_J:     path = '{0, 1, 9};
            OP_ADDI:  path = '{0, 1, 10, 11};
            default:  path = '{0, 1, 15};
        endcase
        trapped = 1'b0;
        f = 6'($urandom);
        bus.instr_op = op;
        bus.funct = f;
        for (int i = 0; i < path.size(); i++) begin
            st = path[i];
            if (st == 15) begin
                trapped = 1'b1;
                break;
            end
            if (st == 0 || st == 3 || st == 5) begin
                w = (st == 0) ? fetchWait : memWait;
                n = (w > WAIT_MAX) ? WAIT_MAX + 1 : w;
                for (int c = 0; c < n; c++) begin
                    @(negedge clk);
                    bus.mem_ready = 1'b0;
                    #1;
                    e = expCtrl(st, 1'b0);
                    checks++;
                    if (actCtrl !== e) begin
                        errors++;
                        $display("[TB] FAIL %s op=%b wait st%0d cyc%0d: got %h expected %h",
                                 tag, op, st, c, actCtrl, e);
                    end
                    @(posedge clk);
                end
                if (w > WAIT_MAX) begin
                    trapped = 1'b1;
                    break;
                end
                @(negedge clk);
                bus.mem_ready = 1'b1;
            end else begin
                @(negedge clk);
                bus.mem_ready = rndReady ? 1'($urandom) : 1'b1;
            end
            #1;
            e = expCtrl(st, bus.mem_ready);
            checks++;
            if (actCtrl !== e) begin
                errors++;
                $display("[TB] FAIL %s op=%b st%0d: got %h expected %h",
                         tag, op, st, actCtrl, e);
            end
            @(posedge clk);
            if (st == 1) begin
                #1;
                checks++;
                if (bus.funct_out !== f) begin
                    errors++;
                    $display("[TB] FAIL %s funct_out: got %b expected %b",
                             tag, bus.funct_out, f);
                end
                bus.funct = 6'($urandom);
            end
        end
        if (trapped) begin
            repeat (3) begin
                @(negedge clk);
                bus.mem_ready = 1'($urandom);
                #1;
                e = expCtrl(15, 1'b0);
                checks++;
                if (actCtrl !== e) begin
                    errors++;
                    $display("[TB] FAIL %s op=%b error state: got %h expected %h",
                             tag, op, actCtrl, e);
                end
                @(posedge clk);
            end
        end else begin
            expCount = expCount + 32'd1;
        end
        #1;
        checks++;
        if (o_instr_count !== expCount) begin
            errors++;
            $display("[TB] FAIL %s instr_count: got %0d expected %0d",
                     tag, o_instr_count, expCount);
        end
    endtask

    task automatic test_reset();
        ctrl_t e;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.instr_op = OP_RTYPE;
        bus.funct = 6'h2a;
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (actCtrl !== zeroCtrl || o_instr_count !== 32'd0 || bus.funct_out !== 6'd0) begin
                errors++;
                $display("[TB] FAIL reset_hold: got ctrl %h count %0d funct_out %b expected all zero",
                         actCtrl, o_instr_count, bus.funct_out);
            end
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        e = expCtrl(0, 1'b1);
        checks++;
        if (actCtrl !== e) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch: got %h expected %h", actCtrl, e);
        end
        applyReset();
    endtask

    task automatic test_sequence();
        run_instr(OP_RTYPE, 0, 0, 1'b0, "seq_add");
        run_instr(OP_LW,    0, 0, 1'b0, "seq_lw");
        run_instr(OP_SW,    0, 0, 1'b0, "seq_sw");
        run_instr(OP_BEQ,   0, 0, 1'b0, "seq_beq");
        run_instr(OP_J,     0, 0, 1'b0, "seq_j");
        run_instr(OP_ADDI,  0, 0, 1'b0, "seq_addi");
        checks++;
        if (o_instr_count !== 32'd6) begin
            errors++;
            $display("[TB] FAIL seq_count: got %0d expected 6", o_instr_count);
        end
    endtask

    task automatic test_lw_wait();
        run_instr(OP_LW, 0, 5, 1'b0, "lw_wait5");
    endtask

    task automatic test_wait_boundary();
        run_instr(OP_SW, WAIT_MAX, WAIT_MAX, 1'b1, "sw_wait_max");
        run_instr(OP_LW, WAIT_MAX, WAIT_MAX, 1'b1, "lw_wait_max");
    endtask

    task automatic test_random();
        logic [5:0] legal [6];
        legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        for (int k = 0; k < 25; k++) begin
            run_instr(legal[$urandom_range(0, 5)],
                      int'($urandom_range(0, WAIT_MAX)),
                      int'($urandom_range(0, WAIT_MAX)), 1'b1, "random");
        end
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 0, 0, 1'b0, "illegal_op");
        applyReset();
    endtask

    task automatic test_fetch_timeout();
        run_instr(OP_RTYPE, WAIT_MAX + 1, 0, 1'b0, "fetch_timeout");
        applyReset();
    endtask

    task automatic test_memwr_timeout();
        run_instr(OP_J, 0, 0, 1'b1, "pre_memwr");
        run_instr(OP_SW, 0, WAIT_MAX + 1, 1'b0, "memwr_timeout");
        applyReset();
    endtask

    task automatic test_async_reset();
        int    stList[3];
        ctrl_t e;
        stList = '{0, 1, 2};
        run_instr(OP_J, 0, 0, 1'b0, "pre_async");
        bus.instr_op = OP_SW;
        bus.funct = 6'h15;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (o_state_dbg !== 4'(stList[i])) begin
                errors++;
                $display("[TB] FAIL async_path: got state %0d expected %0d",
                         o_state_dbg, stList[i]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_write !== 1'b1 || o_state_dbg !== 4'd5) begin
            errors++;
            $display("[TB] FAIL async_memwr: got mem_write %b state %0d expected 1 and 5",
                     bus.mem_write, o_state_dbg);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (actCtrl !== zeroCtrl || o_instr_count !== 32'd0 || bus.funct_out !== 6'd0) begin
            errors++;
            $display("[TB] FAIL async_drop: got ctrl %h count %0d funct_out %b expected all zero",
                     actCtrl, o_instr_count, bus.funct_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        expCount = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        e = expCtrl(0, 1'b1);
        checks++;
        if (actCtrl !== e || o_instr_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL async_release: got ctrl %h count %0d expected %h count 0",
                     actCtrl, o_instr_count, e);
        end
    endtask

    initial begin
        bus.instr_op  = '0;
        bus.funct     = '0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_sequence();
        test_lw_wait();
        test_wait_boundary();
        test_random();
        test_illegal();
        test_fetch_timeout();
        test_memwr_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run so the bench always ends on its own.
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
